// File: rtl/branch_resolve_unit.sv
// EX-stage back end: registers ALU results into EX/MEM, redirects the PC on a taken branch
// and squashes the following wrong-path slots. Optional statistics counters: BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        is_branch_i,
    input  logic        jump_i,
    input  logic [31:0] result_i,
    input  logic [31:0] target_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        pc_src_o,
    output logic [31:0] pc_target_o,
    output logic        flush_o,
    output logic [15:0] branch_cnt_o,
    output logic [15:0] taken_cnt_o
);

    typedef enum logic {IDLE, SHADOW} state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  shadow_cnt_q, shadow_cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        pc_src_q, pc_src_d;
    logic [31:0] pc_target_q, pc_target_d;
    logic        flush_q, flush_d;

    logic accept, live, taken;

    assign accept = valid_i & ~stall_i;
    assign live   = accept & (state_q == IDLE);
    assign taken  = live & is_branch_i & jump_i;

    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        valid_d      = valid_q;
        result_d     = result_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        pc_target_d  = pc_target_q;
        pc_src_d     = 1'b0;
        flush_d      = 1'b0;
        if (!stall_i) begin
            // Squashed slots still capture data; only valid/reg_write are gated.
            valid_d     = live;
            reg_write_d = live & reg_write_i;
            if (accept) begin
                result_d = result_i;
                rd_d     = rd_i;
            end
            case (state_q)
                IDLE: begin
                    if (taken) begin
                        pc_src_d     = 1'b1;
                        flush_d      = 1'b1;
                        pc_target_d  = target_i;
                        shadow_cnt_d = FLUSH_INIT;
                        state_d      = SHADOW;
                    end
                end
                SHADOW: begin
                    if (accept) begin
                        shadow_cnt_d = shadow_cnt_q - 3'd1;
                        if (shadow_cnt_q == 3'd1) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            shadow_cnt_q <= 3'd0;
            valid_q      <= 1'b0;
            result_q     <= 32'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            pc_src_q     <= 1'b0;
            pc_target_q  <= 32'd0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            pc_src_q     <= pc_src_d;
            pc_target_q  <= pc_target_d;
            flush_q      <= flush_d;
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign pc_src_o    = pc_src_q;
    assign pc_target_o = pc_target_q;
    assign flush_o     = flush_q;

`ifdef BRU_STATS_EN
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    // Saturating counters over live (non-shadow, non-stalled) branches only.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (live && is_branch_i) begin
            if (branch_cnt_q != 16'hFFFF) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
            if (jump_i && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q <= 16'd0;
            taken_cnt_q  <= 16'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign taken_cnt_o  = taken_cnt_q;
`else
    assign branch_cnt_o = 16'h0000;
    assign taken_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// compared against a slot-level reference model.
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        is_branch_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] result_i = 32'd0;
    logic [31:0] target_i = 32'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        reg_write_i = 1'b0;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        pc_src_o;
    logic [31:0] pc_target_o;
    logic        flush_o;
    logic [15:0] branch_cnt_o;
    logic [15:0] taken_cnt_o;

    always #5 clk_i = ~clk_i;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .is_branch_i(is_branch_i), .jump_i(jump_i), .result_i(result_i),
        .target_i(target_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
        .pc_src_o(pc_src_o), .pc_target_o(pc_target_o), .flush_o(flush_o),
        .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected EX/MEM contents plus the number of slots still to squash.
    logic        m_valid, m_rw, m_pc_src, m_flush;
    logic [31:0] m_result, m_target;
    logic [4:0]  m_rd;
    int          squash_left;
    int          m_brc, m_tkc;
    bit          data_live;
    int          pulses;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_pc_src = 0; m_flush = 0;
        m_result = 0; m_target = 0; m_rd = 0;
        squash_left = 0; m_brc = 0; m_tkc = 0; data_live = 0;
    endtask

    task automatic model_step();
        m_pc_src = 0;
        m_flush  = 0;
        if (!stall_i) begin
            if (valid_i) begin
                m_result  = result_i;
                m_rd      = rd_i;
                data_live = 1;
                if (squash_left > 0) begin
                    m_valid = 0;
                    m_rw    = 0;
                    squash_left--;
                end else begin
                    m_valid = 1;
                    m_rw    = reg_write_i;
                    if (is_branch_i) begin
                        if (m_brc < 16'hFFFF) m_brc++;
                        if (jump_i) begin
                            if (m_tkc < 16'hFFFF) m_tkc++;
                            m_pc_src    = 1;
                            m_flush     = 1;
                            m_target    = target_i;
                            squash_left = FC;
                        end
                    end
                end
            end else begin
                m_valid   = 0;
                m_rw      = 0;
                data_live = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, valid_o, m_valid);
        check_eq({tag, ".reg_write"}, reg_write_o, m_rw);
        check_eq({tag, ".pc_src"}, pc_src_o, m_pc_src);
        check_eq({tag, ".flush"}, flush_o, m_flush);
        if (m_pc_src) check_eq({tag, ".target"}, pc_target_o, m_target);
        if (data_live) begin
            check_eq({tag, ".result"}, result_o, m_result);
            check_eq({tag, ".rd"}, rd_o, m_rd);
        end
`ifdef BRU_STATS_EN
        check_eq({tag, ".brc"}, branch_cnt_o, 32'(m_brc));
        check_eq({tag, ".tkc"}, taken_cnt_o, 32'(m_tkc));
`else
        check_eq({tag, ".brc"}, branch_cnt_o, 32'd0);
        check_eq({tag, ".tkc"}, taken_cnt_o, 32'd0);
`endif
    endtask

    task automatic cycle(input string tag, input logic v, input logic st, input logic br,
                         input logic j, input logic [31:0] res, input logic [31:0] tgt,
                         input logic [4:0] rd, input logic rw);
        @(negedge clk_i);
        valid_i = v; stall_i = st; is_branch_i = br; jump_i = j;
        result_i = res; target_i = tgt; rd_i = rd; reg_write_i = rw;
        @(posedge clk_i);
        model_step();
        #1;
        check_outputs(tag);
        if (pc_src_o) pulses++;
    endtask

    task automatic add(input string tag, input logic [31:0] res, input logic [4:0] rd);
        cycle(tag, 1, 0, 0, 0, res, 32'h0, rd, 1);
    endtask

    task automatic branch(input string tag, input logic j, input logic [31:0] tgt);
        cycle(tag, 1, 0, 1, j, 32'h0, tgt, 5'd0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 0;
        valid_i = 0; stall_i = 0;
        #1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1;
    endtask

    initial begin
        model_reset();
        pulses = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst.valid", valid_o, 0);
        check_eq("rst.result", result_o, 0);
        check_eq("rst.pc_src", pc_src_o, 0);
        check_eq("rst.target", pc_target_o, 0);
        check_eq("rst.flush", flush_o, 0);
        @(negedge clk_i);
        rst_i = 1;

        // Reset then stream
        add("stream", 32'h7, 5'd5);
        check_eq("stream.result_dir", result_o, 32'h7);
        check_eq("stream.rd_dir", rd_o, 5);

        // Taken branch then three ADDs
        pulses = 0;
        branch("beq", 1, 32'h40);
        check_eq("beq.target_dir", pc_target_o, 32'h40);
        add("sh1", 32'h11, 5'd1);
        add("sh2", 32'h12, 5'd2);
        add("post", 32'h13, 5'd3);
        check_eq("post.valid_dir", valid_o, 1);
        check_eq("beq.pulses", pulses, 1);

        // Not-taken branch, then taken BEQ followed by taken BGT
        branch("bne", 0, 32'h80);
        check_eq("bne.valid_dir", valid_o, 1);
        pulses = 0;
        branch("beq2", 1, 32'h100);
        branch("bgt", 1, 32'h200);
        add("a1", 32'h21, 5'd4);
        add("a2", 32'h22, 5'd6);
        check_eq("beqbgt.pulses", pulses, 1);
        check_eq("beqbgt.target", pc_target_o, 32'h100);

        // Stalls and bubbles inside the shadow
        branch("br_st", 1, 32'h300);
        repeat (3) cycle("stall", 1, 1, 0, 0, 32'h55, 32'h0, 5'd7, 1);
        repeat (2) cycle("bubble", 0, 0, 0, 0, 32'h66, 32'h0, 5'd8, 1);
        add("sq1", 32'h31, 5'd9);
        check_eq("sq1.valid_dir", valid_o, 0);
        add("sq2", 32'h32, 5'd10);
        check_eq("sq2.valid_dir", valid_o, 0);
        add("live", 32'h33, 5'd11);
        check_eq("live.valid_dir", valid_o, 1);

        // Asynchronous reset mid-shadow
        branch("br_ar", 1, 32'h400);
        add("ar_sh", 32'h41, 5'd12);
        @(negedge clk_i);
        #2;
        rst_i = 0;
        #1;
        check_eq("areset.valid", valid_o, 0);
        check_eq("areset.result", result_o, 0);
        check_eq("areset.rd", rd_o, 0);
        check_eq("areset.target", pc_target_o, 0);
        check_eq("areset.pc_src", pc_src_o, 0);
        model_reset();
        valid_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        add("ar_post", 32'h42, 5'd13);
        check_eq("ar_post.valid_dir", valid_o, 1);

        // Statistics: 5 live branches, 3 taken
        do_reset();
        branch("s1", 1, 32'h10); add("s1a", 1, 1); add("s1b", 2, 2);
        branch("s2", 0, 32'h20);
        branch("s3", 1, 32'h30); add("s3a", 3, 3); add("s3b", 4, 4);
        branch("s4", 0, 32'h40);
        branch("s5", 1, 32'h50); add("s5a", 5, 5); add("s5b", 6, 6);
`ifdef BRU_STATS_EN
        check_eq("stats.brc5", branch_cnt_o, 5);
        check_eq("stats.tkc3", taken_cnt_o, 3);
`else
        check_eq("stats.brc_off", branch_cnt_o, 0);
        check_eq("stats.tkc_off", taken_cnt_o, 0);
`endif

        // Randomized traffic, including jump_i noise on non-branch slots
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle("rand", ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 9) < 3), $urandom_range(0, 1), $urandom,
                  {$urandom_range(0, 255), 2'b00}, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 1));
        end

`ifdef BRU_STATS_EN
        // Drive the branch counter into saturation with not-taken branches
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            branch("sat", 0, 32'h0);
        end
        check_eq("sat.brc", branch_cnt_o, 16'hFFFF);
        branch("sat_t1", 1, 32'h8);
        add("sat_a", 1, 1); add("sat_b", 2, 2);
        check_eq("sat.brc_hold", branch_cnt_o, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
